mem_arbiter: RTL and testbench

- Shares the single main-memory port between the instruction-cache and data-cache miss engines.
- Serialises line fills and writebacks, and times each access with a fixed-latency counter.
- Returns data to the winning requester and drives the two pipeline-stall lines (block_pipe_instr_cache, block_pipe_data_cache) consumed by the pipeline control unit.

---
 rtl/mem_arb_pkg.sv | 36 +++
 rtl/arb_rr2.sv | 27 ++
 rtl/mem_arbiter.sv | 153 +++++++++++++++
 tb/tb_mem_arbiter.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the main-memory arbiter between the
// I-cache and D-cache miss engines.
package mem_arb_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_LINE_W = 128;
    localparam int CNT_W      = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IC = 2'd1,
        BUSY_DC = 2'd2,
        RESP    = 2'd3
    } arb_state_t;

    typedef enum logic {
        GNT_IC = 1'b0,
        GNT_DC = 1'b1
    } grant_t;

    // Two-way round-robin choice: a lone requester always wins; on a
    // conflict the side that did not win last time is chosen.
    function automatic grant_t rr_pick(input logic req_ic, input logic req_dc,
                                       input grant_t last);
        grant_t pick;
        if (req_ic && req_dc) begin
            pick = (last == GNT_IC) ? GNT_DC : GNT_IC;
        end else if (req_dc) begin
            pick = GNT_DC;
        end else begin
            pick = GNT_IC;
        end
        return pick;
    endfunction

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin picker with its own last-grant register. Kept as a
// separate block so further memory clients can reuse it.
module arb_rr2 import mem_arb_pkg::*; (
    input  logic   clk,
    input  logic   reset,
    input  logic   req_ic,
    input  logic   req_dc,
    input  logic   commit,
    output logic   valid,
    output grant_t grant
);

    grant_t last_grant_reg;

    assign valid = req_ic | req_dc;
    assign grant = rr_pick(req_ic, req_dc, last_grant_reg);

    // Remember the winner whenever the owner actually accepts a grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_reg <= GNT_IC;
        end else if (commit && valid) begin
            last_grant_reg <= grant;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Main-memory arbiter: serialises I-cache fills and D-cache fills or
// writebacks onto one fixed-latency memory port, returns fill data to the
// winner and produces the two pipeline stall lines.
module mem_arbiter import mem_arb_pkg::*; #(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int LINE_W      = DEF_LINE_W,
    parameter int MEM_LATENCY = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ic_req,
    input  logic [ADDR_W-1:0] ic_addr,
    output logic              ic_ready,
    output logic [LINE_W-1:0] ic_rdata,
    input  logic              dc_req,
    input  logic              dc_we,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic [LINE_W-1:0] dc_wdata,
    output logic              dc_ready,
    output logic [LINE_W-1:0] dc_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    output logic              block_pipe_instr_cache,
    output logic              block_pipe_data_cache
);

    // Final count value of a BUSY phase; MEM_LATENCY is limited to 1..15 so
    // the 4-bit counter never wraps.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MEM_LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    arb_state_t        state_reg;
    logic [CNT_W-1:0]  count_reg;
    logic              mem_req_reg;
    logic              mem_we_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic [LINE_W-1:0] mem_wdata_reg;
    logic              ic_ready_reg;
    logic              dc_ready_reg;
    logic [LINE_W-1:0] ic_rdata_reg;
    logic [LINE_W-1:0] dc_rdata_reg;

    logic   any_req;
    grant_t pick;
    logic   in_idle;

    // Requests are only looked at while the port is idle; RESP is skipped
    // so a requester has one cycle to withdraw after its ready pulse.
    assign in_idle = (state_reg == IDLE);

    arb_rr2 u_rr (
        .clk    (clk),
        .reset  (reset),
        .req_ic (ic_req),
        .req_dc (dc_req),
        .commit (in_idle),
        .valid  (any_req),
        .grant  (pick)
    );

    // Access sequencer: grant, hold the memory port for MEM_LATENCY cycles,
    // capture fill data, then pulse ready for one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            count_reg     <= '0;
            mem_req_reg   <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            ic_ready_reg  <= 1'b0;
            dc_ready_reg  <= 1'b0;
            ic_rdata_reg  <= '0;
            dc_rdata_reg  <= '0;
        end else begin
            ic_ready_reg <= 1'b0;
            dc_ready_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (any_req) begin
                        mem_req_reg <= 1'b1;
                        count_reg   <= '0;
                        if (pick == GNT_DC) begin
                            state_reg     <= BUSY_DC;
                            mem_we_reg    <= dc_we;
                            mem_addr_reg  <= dc_addr;
                            mem_wdata_reg <= dc_wdata;
                        end else begin
                            state_reg    <= BUSY_IC;
                            mem_we_reg   <= 1'b0;
                            mem_addr_reg <= ic_addr;
                        end
                    end
                end
                BUSY_IC, BUSY_DC: begin
                    if (count_reg == LAST_CNT) begin
                        count_reg   <= '0;
                        mem_req_reg <= 1'b0;
                        mem_we_reg  <= 1'b0;
                        state_reg   <= RESP;
                        if (state_reg == BUSY_IC) begin
                            ic_rdata_reg <= mem_rdata;
                            ic_ready_reg <= 1'b1;
                        end else begin
                            // Writebacks leave the previous fill data visible.
                            if (!mem_we_reg) begin
                                dc_rdata_reg <= mem_rdata;
                            end
                            dc_ready_reg <= 1'b1;
                        end
                    end else begin
                        count_reg <= count_reg + CNT_ONE;
                    end
                end
                RESP: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign mem_req   = mem_req_reg;
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign ic_ready  = ic_ready_reg;
    assign dc_ready  = dc_ready_reg;
    assign ic_rdata  = ic_rdata_reg;
    assign dc_rdata  = dc_rdata_reg;

    // Stall each pipeline side while its request is outstanding and not
    // being completed this cycle (index 0 = I-side, 1 = D-side).
    logic [1:0] req_vec;
    logic [1:0] ready_vec;
    logic [1:0] stall_vec;

    assign req_vec   = {dc_req, ic_req};
    assign ready_vec = {dc_ready_reg, ic_ready_reg};

    for (genvar gi = 0; gi < 2; gi++) begin : g_stall
        assign stall_vec[gi] = req_vec[gi] & ~ready_vec[gi];
    end

    assign block_pipe_instr_cache = stall_vec[0];
    assign block_pipe_data_cache  = stall_vec[1];

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus a randomized run checked
// against a transaction-timeline model of the arbiter.
module tb_mem_arbiter;

    localparam int AW   = 32;
    localparam int LW   = 128;
    localparam int LAT  = 4;
    localparam int LAT1 = 1;

    logic          clk = 1'b0;
    logic          reset;
    int            errors = 0;
    int            checks = 0;

    // Main instance (MEM_LATENCY = 4)
    logic          ic_req, ic_ready, dc_req, dc_we, dc_ready;
    logic [AW-1:0] ic_addr, dc_addr, mem_addr;
    logic [LW-1:0] ic_rdata, dc_wdata, dc_rdata, mem_wdata, mem_rdata;
    logic          mem_req, mem_we, block_pipe_instr_cache, block_pipe_data_cache;
    logic [LW-1:0] mem_fill;
    int            mcnt = 0;

    // Second instance (MEM_LATENCY = 1), I-side only
    logic          ic_req1, ic_ready1, dc_req1, dc_we1, dc_ready1;
    logic [AW-1:0] ic_addr1, dc_addr1, mem_addr1;
    logic [LW-1:0] ic_rdata1, dc_wdata1, dc_rdata1, mem_wdata1, mem_rdata1;
    logic          mem_req1, mem_we1, bpi1, bpd1;
    logic [LW-1:0] mem_fill1;
    int            mcnt1 = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .LINE_W(LW), .MEM_LATENCY(LAT)) dut (
        .clk(clk), .reset(reset),
        .ic_req(ic_req), .ic_addr(ic_addr), .ic_ready(ic_ready), .ic_rdata(ic_rdata),
        .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
        .dc_ready(dc_ready), .dc_rdata(dc_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .block_pipe_instr_cache(block_pipe_instr_cache),
        .block_pipe_data_cache(block_pipe_data_cache)
    );

    mem_arbiter #(.ADDR_W(AW), .LINE_W(LW), .MEM_LATENCY(LAT1)) dut1 (
        .clk(clk), .reset(reset),
        .ic_req(ic_req1), .ic_addr(ic_addr1), .ic_ready(ic_ready1), .ic_rdata(ic_rdata1),
        .dc_req(dc_req1), .dc_we(dc_we1), .dc_addr(dc_addr1), .dc_wdata(dc_wdata1),
        .dc_ready(dc_ready1), .dc_rdata(dc_rdata1),
        .mem_req(mem_req1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
        .mem_rdata(mem_rdata1),
        .block_pipe_instr_cache(bpi1),
        .block_pipe_data_cache(bpd1)
    );

    // Memory models: fill data is valid only in the last cycle of a burst
    // of mem_req; any other cycle returns the inverted pattern.
    always @(posedge clk) begin
        mcnt  <= (mem_req  === 1'b1) ? mcnt + 1  : 0;
        mcnt1 <= (mem_req1 === 1'b1) ? mcnt1 + 1 : 0;
    end
    assign mem_rdata  = (mem_req  === 1'b1 && mcnt  == LAT - 1)  ? mem_fill  : ~mem_fill;
    assign mem_rdata1 = (mem_req1 === 1'b1 && mcnt1 == LAT1 - 1) ? mem_fill1 : ~mem_fill1;

    // Leaves the bench at the falling edge of the first IDLE cycle (cycle 0).
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; ic_req = 1'b0; dc_req = 1'b0; dc_we = 1'b0; ic_req1 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Runs one D-side fill to completion without cycle-level checks.
    task automatic run_dc_fill(input logic [AW-1:0] addr, input logic [LW-1:0] fill);
        bit seen;
        seen = 1'b0;
        mem_fill = fill; dc_req = 1'b1; dc_we = 1'b0; dc_addr = addr;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (dc_ready === 1'b1) seen = 1'b1;
        end
        dc_req = 1'b0;
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL dc_fill_timeout got=no_ready required=ready");
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1; ic_req = 1'b1; dc_req = 1'b1; dc_we = 1'b1; ic_req1 = 1'b1;
        ic_addr = 32'h1; dc_addr = 32'h2; dc_wdata = '1; mem_fill = '0; mem_fill1 = '0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (mem_req !== 1'b0)   begin errors++; $display("FAIL reset_mem_req got=%b required=0", mem_req); end
        checks++; if (mem_we !== 1'b0)    begin errors++; $display("FAIL reset_mem_we got=%b required=0", mem_we); end
        checks++; if (ic_ready !== 1'b0)  begin errors++; $display("FAIL reset_ic_ready got=%b required=0", ic_ready); end
        checks++; if (dc_ready !== 1'b0)  begin errors++; $display("FAIL reset_dc_ready got=%b required=0", dc_ready); end
        checks++; if (mem_addr !== '0)    begin errors++; $display("FAIL reset_mem_addr got=%h required=0", mem_addr); end
        checks++; if (mem_wdata !== '0)   begin errors++; $display("FAIL reset_mem_wdata got=%h required=0", mem_wdata); end
        checks++; if (ic_rdata !== '0)    begin errors++; $display("FAIL reset_ic_rdata got=%h required=0", ic_rdata); end
        checks++; if (dc_rdata !== '0)    begin errors++; $display("FAIL reset_dc_rdata got=%h required=0", dc_rdata); end
        checks++; if (mem_req1 !== 1'b0)  begin errors++; $display("FAIL reset_mem_req1 got=%b required=0", mem_req1); end
        $display("txn reset: outputs checked under reset");
    endtask

    task automatic test_ic_fill();
        logic e;
        int   pulses;
        pulses = 0;
        do_reset();
        mem_fill = {16{8'hA5}};
        ic_req = 1'b1; ic_addr = 32'h100;
        #1;
        checks++; if (block_pipe_instr_cache !== 1'b1) begin errors++; $display("FAIL ic_fill_block c=0 got=%b required=1", block_pipe_instr_cache); end
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            e = (c >= 1 && c <= LAT);
            checks++; if (mem_req !== e) begin errors++; $display("FAIL ic_fill_mem_req c=%0d got=%b required=%b", c, mem_req, e); end
            if (e) begin
                checks++; if (mem_addr !== 32'h100) begin errors++; $display("FAIL ic_fill_mem_addr c=%0d got=%h required=100", c, mem_addr); end
                checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL ic_fill_mem_we c=%0d got=%b required=0", c, mem_we); end
            end
            e = (c == LAT + 1);
            checks++; if (ic_ready !== e) begin errors++; $display("FAIL ic_fill_ready c=%0d got=%b required=%b", c, ic_ready, e); end
            if (ic_ready === 1'b1) pulses++;
            checks++; if (dc_ready !== 1'b0) begin errors++; $display("FAIL ic_fill_dc_ready c=%0d got=%b required=0", c, dc_ready); end
            e = (c <= LAT);
            checks++; if (block_pipe_instr_cache !== e) begin errors++; $display("FAIL ic_fill_block c=%0d got=%b required=%b", c, block_pipe_instr_cache, e); end
            if (c == LAT + 1) begin
                checks++; if (ic_rdata !== {16{8'hA5}}) begin errors++; $display("FAIL ic_fill_rdata got=%h required=a5..a5", ic_rdata); end
                ic_req = 1'b0;
            end
        end
        checks++; if (pulses != 1) begin errors++; $display("FAIL ic_fill_pulses got=%0d required=1", pulses); end
        $display("txn ic_fill addr=100 ready_pulses=%0d", pulses);
    endtask

    task automatic test_dc_writeback();
        logic           e;
        logic [LW-1:0]  f1;
        f1 = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
        do_reset();
        run_dc_fill(32'h40, f1);
        mem_fill = ~f1;
        dc_req = 1'b1; dc_we = 1'b1; dc_addr = 32'h2000; dc_wdata = 128'h1234;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            e = (c >= 1 && c <= LAT);
            checks++; if (mem_req !== e) begin errors++; $display("FAIL wb_mem_req c=%0d got=%b required=%b", c, mem_req, e); end
            if (e) begin
                checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL wb_mem_we c=%0d got=%b required=1", c, mem_we); end
                checks++; if (mem_wdata !== 128'h1234) begin errors++; $display("FAIL wb_mem_wdata c=%0d got=%h required=1234", c, mem_wdata); end
                checks++; if (mem_addr !== 32'h2000) begin errors++; $display("FAIL wb_mem_addr c=%0d got=%h required=2000", c, mem_addr); end
            end
            e = (c == LAT + 1);
            checks++; if (dc_ready !== e) begin errors++; $display("FAIL wb_dc_ready c=%0d got=%b required=%b", c, dc_ready, e); end
            checks++; if (dc_rdata !== f1) begin errors++; $display("FAIL wb_dc_rdata c=%0d got=%h required=%h", c, dc_rdata, f1); end
            if (e) dc_req = 1'b0;
        end
        dc_we = 1'b0;
        $display("txn dc_writeback addr=2000 wdata=1234");
    endtask

    task automatic test_conflict();
        logic          first_dc, e;
        logic [LW-1:0] fill;
        do_reset();
        for (int round = 0; round < 2; round++) begin
            // Round 1 follows a lone DC fill, so IC must win the conflict.
            if (round == 1) run_dc_fill(32'h60, 128'h5a5a);
            first_dc = (round == 0);
            fill = {$urandom, $urandom, $urandom, $urandom};
            mem_fill = fill;
            ic_req = 1'b1; ic_addr = 32'hA00 + round;
            dc_req = 1'b1; dc_we = 1'b0; dc_addr = 32'hB00 + round;
            for (int c = 1; c <= 12; c++) begin
                @(negedge clk);
                e = first_dc ? (c == 11) : (c == 5);
                checks++; if (ic_ready !== e) begin errors++; $display("FAIL conflict%0d_ic_ready c=%0d got=%b required=%b", round, c, ic_ready, e); end
                if (e) begin
                    checks++; if (ic_rdata !== fill) begin errors++; $display("FAIL conflict%0d_ic_rdata got=%h required=%h", round, ic_rdata, fill); end
                    ic_req = 1'b0;
                end
                e = first_dc ? (c == 5) : (c == 11);
                checks++; if (dc_ready !== e) begin errors++; $display("FAIL conflict%0d_dc_ready c=%0d got=%b required=%b", round, c, dc_ready, e); end
                if (e) begin
                    checks++; if (dc_rdata !== fill) begin errors++; $display("FAIL conflict%0d_dc_rdata got=%h required=%h", round, dc_rdata, fill); end
                    dc_req = 1'b0;
                end
                if (c >= 1 && c <= 4) begin
                    checks++;
                    if (mem_addr !== (first_dc ? 32'hB00 + round : 32'hA00 + round)) begin
                        errors++; $display("FAIL conflict%0d_first_addr c=%0d got=%h", round, c, mem_addr);
                    end
                end
                if (c >= 7 && c <= 10) begin
                    checks++;
                    if (mem_addr !== (first_dc ? 32'hA00 + round : 32'hB00 + round)) begin
                        errors++; $display("FAIL conflict%0d_second_addr c=%0d got=%h", round, c, mem_addr);
                    end
                end
            end
            $display("txn conflict round=%0d first=%s", round, first_dc ? "DC" : "IC");
        end
    endtask

    task automatic test_back_to_back();
        logic e;
        int   pulses;
        pulses = 0;
        do_reset();
        mem_fill = {4{$urandom}};
        ic_req = 1'b1; ic_addr = 32'h7700;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            e = (c == 5 || c == 11 || c == 17);
            checks++; if (ic_ready !== e) begin errors++; $display("FAIL b2b_ready c=%0d got=%b required=%b", c, ic_ready, e); end
            if (ic_ready === 1'b1) pulses++;
            e = ((c % 6) >= 1 && (c % 6) <= 4 && c < 17);
            checks++; if (mem_req !== e) begin errors++; $display("FAIL b2b_mem_req c=%0d got=%b required=%b", c, mem_req, e); end
            if (c == 17) ic_req = 1'b0;
        end
        checks++; if (pulses != 3) begin errors++; $display("FAIL b2b_pulses got=%0d required=3", pulses); end
        $display("txn back_to_back fills=3 pulses=%0d", pulses);
    endtask

    task automatic test_reset_abort();
        logic e;
        do_reset();
        mem_fill = {4{32'hC0DE_0001}};
        dc_req = 1'b1; dc_we = 1'b0; dc_addr = 32'h300;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            e = (c >= 1 && c <= 2) || (c >= 4 && c <= 7);
            checks++; if (mem_req !== e) begin errors++; $display("FAIL abort_mem_req c=%0d got=%b required=%b", c, mem_req, e); end
            checks++; if (dc_ready !== 1'b0) begin errors++; $display("FAIL abort_dc_ready c=%0d got=%b required=0", c, dc_ready); end
            if (c == 3) begin
                checks++; if (mem_addr !== '0) begin errors++; $display("FAIL abort_mem_addr got=%h required=0", mem_addr); end
            end
            if (c >= 4 && c <= 7) begin
                checks++; if (mem_addr !== 32'h500) begin errors++; $display("FAIL abort_new_addr c=%0d got=%h required=500", c, mem_addr); end
            end
            e = (c == 8);
            checks++; if (ic_ready !== e) begin errors++; $display("FAIL abort_ic_ready c=%0d got=%b required=%b", c, ic_ready, e); end
            if (e) begin
                checks++; if (ic_rdata !== mem_fill) begin errors++; $display("FAIL abort_ic_rdata got=%h required=%h", ic_rdata, mem_fill); end
                ic_req = 1'b0;
            end
            if (c == 2) begin reset = 1'b1; dc_req = 1'b0; end
            if (c == 3) begin reset = 1'b0; ic_req = 1'b1; ic_addr = 32'h500; end
        end
        $display("txn reset_abort dc_fill aborted, ic_fill addr=500 served");
    endtask

    task automatic test_latency1();
        logic e;
        do_reset();
        mem_fill1 = {4{32'h1357_9BDF}};
        ic_req1 = 1'b1; ic_addr1 = 32'h80;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            e = (c == 1);
            checks++; if (mem_req1 !== e) begin errors++; $display("FAIL lat1_mem_req c=%0d got=%b required=%b", c, mem_req1, e); end
            if (e) begin
                checks++; if (mem_addr1 !== 32'h80) begin errors++; $display("FAIL lat1_mem_addr got=%h required=80", mem_addr1); end
            end
            e = (c == 2);
            checks++; if (ic_ready1 !== e) begin errors++; $display("FAIL lat1_ic_ready c=%0d got=%b required=%b", c, ic_ready1, e); end
            if (e) begin
                checks++; if (ic_rdata1 !== mem_fill1) begin errors++; $display("FAIL lat1_ic_rdata got=%h required=%h", ic_rdata1, mem_fill1); end
                ic_req1 = 1'b0;
            end
        end
        $display("txn latency1 ic_fill addr=80");
    endtask

    // Randomized traffic against a timeline model: a grant at cycle t0
    // occupies the port during t0+1..t0+LAT, completes at t0+LAT+1 and the
    // next grant can happen no earlier than t0+LAT+2.
    task automatic test_random();
        int            t0, side, last, ntx;
        logic [AW-1:0] l_addr;
        logic          l_we;
        logic [LW-1:0] l_wdata, e_ic_rd, e_dc_rd, fill_now;
        logic          e_mreq, e_icr, e_dcr, e;
        do_reset();
        t0 = -100; side = 0; last = 0; ntx = 0;
        l_addr = '0; l_we = 1'b0; l_wdata = '0; e_ic_rd = '0; e_dc_rd = '0;
        for (int c = 0; c < 600; c++) begin
            if (c > 0) @(negedge clk);
            e_mreq = (c >= t0 + 1 && c <= t0 + LAT);
            e_icr  = (side == 0 && c == t0 + LAT + 1);
            e_dcr  = (side == 1 && c == t0 + LAT + 1);
            checks++; if (mem_req !== e_mreq) begin errors++; $display("FAIL rnd_mem_req c=%0d got=%b required=%b", c, mem_req, e_mreq); end
            checks++; if (ic_ready !== e_icr) begin errors++; $display("FAIL rnd_ic_ready c=%0d got=%b required=%b", c, ic_ready, e_icr); end
            checks++; if (dc_ready !== e_dcr) begin errors++; $display("FAIL rnd_dc_ready c=%0d got=%b required=%b", c, dc_ready, e_dcr); end
            checks++; if (ic_rdata !== e_ic_rd) begin errors++; $display("FAIL rnd_ic_rdata c=%0d got=%h required=%h", c, ic_rdata, e_ic_rd); end
            checks++; if (dc_rdata !== e_dc_rd) begin errors++; $display("FAIL rnd_dc_rdata c=%0d got=%h required=%h", c, dc_rdata, e_dc_rd); end
            e = ic_req & ~e_icr;
            checks++; if (block_pipe_instr_cache !== e) begin errors++; $display("FAIL rnd_block_ic c=%0d got=%b required=%b", c, block_pipe_instr_cache, e); end
            e = dc_req & ~e_dcr;
            checks++; if (block_pipe_data_cache !== e) begin errors++; $display("FAIL rnd_block_dc c=%0d got=%b required=%b", c, block_pipe_data_cache, e); end
            if (e_mreq) begin
                checks++; if (mem_addr !== l_addr) begin errors++; $display("FAIL rnd_mem_addr c=%0d got=%h required=%h", c, mem_addr, l_addr); end
                checks++; if (mem_we !== l_we) begin errors++; $display("FAIL rnd_mem_we c=%0d got=%b required=%b", c, mem_we, l_we); end
                if (l_we) begin
                    checks++; if (mem_wdata !== l_wdata) begin errors++; $display("FAIL rnd_mem_wdata c=%0d got=%h required=%h", c, mem_wdata, l_wdata); end
                end
            end
            // Requesters: hold until ready, then either drop or issue anew.
            if (ic_req) begin
                if (e_icr && $urandom_range(1, 0) == 0) ic_req = 1'b0;
            end else if ($urandom_range(2, 0) == 0) begin
                ic_req = 1'b1;
            end
            if (dc_req) begin
                if (e_dcr) begin
                    if ($urandom_range(1, 0) == 0) dc_req = 1'b0;
                    else dc_we = 1'($urandom_range(1, 0));
                end
            end else if ($urandom_range(2, 0) == 0) begin
                dc_req = 1'b1; dc_we = 1'($urandom_range(1, 0));
            end
            // Address/data wander freely; only the copy taken at grant counts.
            if ($urandom_range(3, 0) == 0) ic_addr = $urandom;
            if ($urandom_range(3, 0) == 0) dc_addr = $urandom;
            if ($urandom_range(3, 0) == 0) dc_wdata = {$urandom, $urandom, $urandom, $urandom};
            fill_now = {$urandom, $urandom, $urandom, $urandom};
            mem_fill = fill_now;
            if (c == t0 + LAT) begin
                if (side == 0) e_ic_rd = fill_now;
                else if (!l_we) e_dc_rd = fill_now;
            end
            if (c >= t0 + LAT + 2 && (ic_req || dc_req)) begin
                if (ic_req && dc_req) side = 1 - last;
                else side = dc_req ? 1 : 0;
                last    = side;
                t0      = c;
                l_addr  = (side == 1) ? dc_addr : ic_addr;
                l_we    = (side == 1) ? dc_we : 1'b0;
                l_wdata = dc_wdata;
                ntx++;
                $display("txn rnd #%0d cycle=%0d side=%s we=%b addr=%h", ntx, c, (side == 1) ? "DC" : "IC", l_we, l_addr);
            end
        end
        ic_req = 1'b0; dc_req = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        ic_req = 1'b0; ic_addr = '0;
        dc_req = 1'b0; dc_we = 1'b0; dc_addr = '0; dc_wdata = '0;
        ic_req1 = 1'b0; ic_addr1 = '0;
        dc_req1 = 1'b0; dc_we1 = 1'b0; dc_addr1 = '0; dc_wdata1 = '0;
        mem_fill = '0; mem_fill1 = '0;
        test_reset();
        test_ic_fill();
        test_dc_writeback();
        test_conflict();
        test_back_to_back();
        test_reset_abort();
        test_latency1();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
